// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage data-memory access path.
// - funct3 encodings for load/store access size and signedness
// - mem_state_t: state encoding of the access FSM
// - mem_req_t: request and write-back fields held while an access is in flight
// - helpers for access legality, store byte enables and store lane replication
package riscv_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } mem_state_t;

   typedef struct packed {
      logic [31:0] addr;       // word-aligned request address
      logic [31:0] wdata;      // lane-replicated store data
      logic [3:0]  be;         // byte enables
      logic        we;         // 1 = store
      logic [2:0]  funct3;     // access size/sign, reused for load extension
      logic [1:0]  byte_off;   // original addr[1:0]
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_to_reg;
      logic [31:0] alu_out;    // full effective address, forwarded to WB
   } mem_req_t;

   // Illegal size/sign encoding or an address not aligned to the access size.
   function automatic logic access_illegal(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
      logic bad_f3;
      logic bad_align;
      case (f3)
         F3_B, F3_H, F3_W: bad_f3 = 1'b0;
         F3_BU, F3_HU:     bad_f3 = is_store;
         default:          bad_f3 = 1'b1;
      endcase
      bad_align = ((f3[1:0] == 2'b01) && off[0]) ||
                  ((f3[1:0] == 2'b10) && (off != 2'b00));
      return bad_f3 | bad_align;
   endfunction

   function automatic logic [3:0] store_be(input logic [2:0] f3,
                                           input logic [1:0] off);
      logic [3:0] be;
      case (f3[1:0])
         2'b00:   be = 4'b0001 << off;
         2'b01:   be = 4'b0011 << off;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   // Replicating the data across lanes lets memory pick bytes by be alone.
   function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                               input logic [31:0] d);
      logic [31:0] w;
      case (f3[1:0])
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

endpackage

// File: rtl/load_extend.sv
// Selects the byte/halfword addressed by byte_off from a raw 32-bit read word
// and sign- or zero-extends it according to funct3. Word loads pass through.
// Ports:
//   funct3   - load size/sign encoding
//   byte_off - original address bits [1:0]
//   rdata    - raw word returned by data memory
//   data     - extended load result
module load_extend
   import riscv_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  byte_off,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (byte_off)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = byte_off[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'b0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'b0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit. Takes the EX/MEM register, issues a
// valid/ready request to data memory, extends load data and drives MEM/WB.
// The pipeline is frozen (mem_stall) while an access is outstanding.
// Ports:
//   clk, rst            - core clock, synchronous active-high reset
//   EX_MEM_*            - incoming EX/MEM pipeline register fields
//   dmem_req_*          - request channel (valid/ready, we, addr, wdata, be)
//   dmem_rsp_*          - single-cycle response/ack with raw read word
//   mem_stall           - freeze IF..EX/MEM this cycle
//   misalign_exc        - one-cycle pulse for a misaligned/illegal access
//   MEM_WB_*            - registered write-back fields
//
// state | meaning
// IDLE  | no access in flight; non-memory ops pass to MEM/WB in one cycle
// REQ   | request presented, holding fields stable until dmem_req_ready
// WAIT  | request accepted, waiting for dmem_rsp_valid
module mem_access_unit
   import riscv_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int RESP_TIMEOUT = 0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            EX_MEM_valid,
   input  logic            EX_MEM_mem_read,
   input  logic            EX_MEM_mem_write,
   input  logic [2:0]      EX_MEM_funct3,
   input  logic [XLEN-1:0] EX_MEM_alu_out,
   input  logic [XLEN-1:0] EX_MEM_rs2_data,
   input  logic [4:0]      EX_MEM_rd,
   input  logic            EX_MEM_reg_write,
   input  logic            EX_MEM_mem_to_reg,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_req_we,
   output logic [XLEN-1:0] dmem_req_addr,
   output logic [XLEN-1:0] dmem_req_wdata,
   output logic [3:0]      dmem_req_be,
   input  logic            dmem_rsp_valid,
   input  logic [XLEN-1:0] dmem_rsp_rdata,
   output logic            mem_stall,
   output logic            misalign_exc,
   output logic            MEM_WB_reg_write,
   output logic            MEM_WB_mem_to_reg,
   output logic [4:0]      MEM_WB_rd,
   output logic [XLEN-1:0] MEM_WB_mem_data,
   output logic [XLEN-1:0] MEM_WB_alu_out
);

   // Only a 32-bit datapath without response timeout is implemented.
   if (XLEN != 32 || RESP_TIMEOUT != 0) begin : g_cfg_check
      $error("mem_access_unit: only XLEN=32 and RESP_TIMEOUT=0 are supported");
   end

   mem_state_t  state_q, state_d;
   mem_req_t    req_q, req_d;
   logic        misalign_q, misalign_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic        wb_mem_to_reg_q, wb_mem_to_reg_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic [31:0] wb_mem_data_q, wb_mem_data_d;
   logic [31:0] wb_alu_out_q, wb_alu_out_d;

   logic        is_memop;
   logic        is_store;
   logic        illegal;
   logic        in_idle;
   logic [31:0] load_data;

   assign is_memop = EX_MEM_valid & (EX_MEM_mem_read | EX_MEM_mem_write);
   // A read request wins if both flags are ever set together.
   assign is_store = EX_MEM_mem_write & ~EX_MEM_mem_read;
   assign illegal  = access_illegal(is_store, EX_MEM_funct3, EX_MEM_alu_out[1:0]);
   assign in_idle  = (state_q == IDLE);

   load_extend u_load_extend (
      .funct3   (req_q.funct3),
      .byte_off (req_q.byte_off),
      .rdata    (dmem_rsp_rdata),
      .data     (load_data)
   );

   always_comb begin
      state_d         = state_q;
      req_d           = req_q;
      misalign_d      = 1'b0;
      // Any cycle that does not complete an instruction writes a bubble.
      wb_reg_write_d  = 1'b0;
      wb_mem_to_reg_d = wb_mem_to_reg_q;
      wb_rd_d         = wb_rd_q;
      wb_mem_data_d   = wb_mem_data_q;
      wb_alu_out_d    = wb_alu_out_q;

      unique case (state_q)
         IDLE: begin
            if (!is_memop) begin
               wb_reg_write_d  = EX_MEM_valid & EX_MEM_reg_write;
               wb_mem_to_reg_d = EX_MEM_mem_to_reg;
               wb_rd_d         = EX_MEM_rd;
               wb_mem_data_d   = 32'b0;
               wb_alu_out_d    = EX_MEM_alu_out;
            end else if (illegal) begin
               misalign_d = 1'b1;
            end else begin
               req_d.addr       = {EX_MEM_alu_out[31:2], 2'b00};
               req_d.wdata      = store_wdata(EX_MEM_funct3, EX_MEM_rs2_data);
               req_d.be         = is_store ? store_be(EX_MEM_funct3, EX_MEM_alu_out[1:0])
                                           : 4'b1111;
               req_d.we         = is_store;
               req_d.funct3     = EX_MEM_funct3;
               req_d.byte_off   = EX_MEM_alu_out[1:0];
               req_d.rd         = EX_MEM_rd;
               req_d.reg_write  = EX_MEM_reg_write;
               req_d.mem_to_reg = EX_MEM_mem_to_reg;
               req_d.alu_out    = EX_MEM_alu_out;
               state_d          = REQ;
            end
         end
         REQ: begin
            if (dmem_req_ready) begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (dmem_rsp_valid) begin
               wb_reg_write_d  = req_q.reg_write & ~req_q.we;
               wb_mem_to_reg_d = req_q.mem_to_reg;
               wb_rd_d         = req_q.rd;
               wb_mem_data_d   = req_q.we ? 32'b0 : load_data;
               wb_alu_out_d    = req_q.alu_out;
               state_d         = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         req_q           <= '0;
         misalign_q      <= 1'b0;
         wb_reg_write_q  <= 1'b0;
         wb_mem_to_reg_q <= 1'b0;
         wb_rd_q         <= 5'b0;
         wb_mem_data_q   <= 32'b0;
         wb_alu_out_q    <= 32'b0;
      end else begin
         state_q         <= state_d;
         req_q           <= req_d;
         misalign_q      <= misalign_d;
         wb_reg_write_q  <= wb_reg_write_d;
         wb_mem_to_reg_q <= wb_mem_to_reg_d;
         wb_rd_q         <= wb_rd_d;
         wb_mem_data_q   <= wb_mem_data_d;
         wb_alu_out_q    <= wb_alu_out_d;
      end
   end

   // Request fields are forced to zero outside REQ so the bus is quiet.
   assign dmem_req_valid = (state_q == REQ);
   assign dmem_req_we    = dmem_req_valid & req_q.we;
   assign dmem_req_addr  = dmem_req_valid ? req_q.addr  : 32'b0;
   assign dmem_req_wdata = dmem_req_valid ? req_q.wdata : 32'b0;
   assign dmem_req_be    = dmem_req_valid ? req_q.be    : 4'b0;

   assign mem_stall = (in_idle & is_memop & ~illegal) |
                      (state_q == REQ) |
                      ((state_q == WAIT) & ~dmem_rsp_valid);

   assign misalign_exc      = misalign_q;
   assign MEM_WB_reg_write  = wb_reg_write_q;
   assign MEM_WB_mem_to_reg = wb_mem_to_reg_q;
   assign MEM_WB_rd         = wb_rd_q;
   assign MEM_WB_mem_data   = wb_mem_data_q;
   assign MEM_WB_alu_out    = wb_alu_out_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage data-memory access unit of the 5-stage RISC-V pipeline.
- Consumes the EX/MEM pipeline register and issues a valid/ready request to data memory.
- Aligns and extends load data and produces the MEM/WB register fields (mem data, ALU result, rd, control) read by the write-back stage.
- Stalls the pipeline while a memory transaction is outstanding.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESP_TIMEOUT, 0, reserved; must be 0 (no timeout logic).

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- EX_MEM_valid  input  1  EX/MEM holds a real instruction
- EX_MEM_mem_read  input  1  load
- EX_MEM_mem_write  input  1  store
- EX_MEM_funct3  input  3  access size/sign
- EX_MEM_alu_out  input  32  effective address or ALU result
- EX_MEM_rs2_data  input  32  store data
- EX_MEM_rd  input  5  destination register
- EX_MEM_reg_write  input  1  writes rd
- EX_MEM_mem_to_reg  input  1  WB selects memory data
- dmem_req_valid  output  1  request valid
- dmem_req_ready  input  1  memory accepts request
- dmem_req_we  output  1  1=store
- dmem_req_addr  output  32  word address, bits [1:0]=0
- dmem_req_wdata  output  32  lane-replicated store data
- dmem_req_be  output  4  byte enables
- dmem_rsp_valid  input  1  response/ack valid, single cycle
- dmem_rsp_rdata  input  32  raw read word
- mem_stall  output  1  freeze IF..EX/MEM this cycle
- misalign_exc  output  1  one-cycle misaligned/illegal access pulse
- MEM_WB_reg_write, MEM_WB_mem_to_reg  output  1 each  registered control
- MEM_WB_rd  output  5  registered rd
- MEM_WB_mem_data  output  32  extended load data
- MEM_WB_alu_out  output  32  registered ALU result

Behaviour:
- Clock/reset: one clock; rst synchronous and active-high.
- Reset: state=IDLE; every registered output, dmem_req_* and misalign_exc = 0.
- Reset mid-transaction: abandon the access. A later dmem_rsp_valid seen in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT.
- IDLE, no valid memory op (non-memory op or EX_MEM_valid=0):
  - Copy the EX/MEM fields to MEM/WB on the next edge; MEM_WB_mem_data=0.
  - MEM_WB_reg_write = EX_MEM_valid & EX_MEM_reg_write.
  - Latency is 1 cycle; no stall.
- IDLE, valid mem op, aligned:
  - Capture address, data, funct3, rd and control.
  - Go to REQ; mem_stall=1.
  - MEM_WB_reg_write<=0 (bubble).
- IDLE, valid mem op, misaligned:
  - Misaligned means: H with addr[0]=1, W with addr[1:0]!=0, or funct3 not in {000,001,010,100,101} for loads / {000,001,010} for stores.
  - No request is issued.
  - misalign_exc=1 on the next cycle for one cycle; MEM_WB_reg_write<=0; no stall.
- REQ:
  - dmem_req_valid=1, with request fields stable, until dmem_req_ready.
  - On ready, go to WAIT. dmem_rsp_valid in REQ is ignored.
- WAIT:
  - mem_stall = !dmem_rsp_valid.
  - On rsp_valid: load MEM/WB (load data via extend; stores write MEM_WB_reg_write=0) and go to IDLE.
- mem_stall = (IDLE & valid memop & aligned) | REQ | (WAIT & !dmem_rsp_valid).
- Every stalled cycle writes a bubble (MEM_WB_reg_write=0).
- Minimum load latency (ready in REQ, rsp the next cycle): MEM/WB is valid 3 edges after the op appears.
- Store enables:
  - SB: be=0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=1111, wdata=rs2.
- Loads: be=1111. Select the byte/halfword at addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU); LW passes through.
- Simultaneous events: rsp_valid in WAIT together with a new EX/MEM op is not possible, because EX/MEM advances only on that edge. The new op is evaluated in IDLE on the following cycle.

Decomposition:
- Shared package riscv_pkg holds:
  - funct3 constants F3_B/H/W/BU/HU;
  - mem_state_t enum {IDLE, REQ, WAIT};
  - a captured-request struct.
- One combinational sub-module, load_extend(funct3, byte_off, rdata) -> 32-bit data. Its exhaustive test is reused by the unit.

Test Plan:
- LW addr 0x100, ready in REQ, rsp next cycle rdata 0xDEADBEEF, rd=5 -> mem_stall high 2 cycles; MEM_WB_mem_data=0xDEADBEEF, rd=5, reg_write=1, mem_to_reg=1 on the 3rd edge.
- LB addr 0x103 rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; LH addr 0x102 rdata 0x8001_0000 -> 0xFFFF8001.
- SH addr 0x202 rs2=0x1234ABCD, ready held low 3 cycles -> req_valid/addr 0x200/be 1100/wdata 0xABCDABCD stable all 3 cycles; MEM_WB_reg_write=0 after ack.
- LW addr 0x101 -> no dmem_req_valid, misalign_exc pulse 1 cycle, no stall, MEM_WB_reg_write=0.
- ADD result 0x55, rd=7 back-to-back with LW -> ADD reaches MEM/WB in 1 cycle; LW then stalls; ordering preserved.
- rst asserted in WAIT, then rsp_valid arrives -> state IDLE, all outputs 0, response ignored, no MEM/WB write.
